hazard_stall_unit: RTL and testbench

- Drives the control side of the ID/EX pipeline register's interface: generates `stall`, `superStall` and `flush`, which that register and IF/ID consume.
- Detects register-operand hazards between the instruction in ID and the instructions in EXE/MEM.
- Holds the whole pipeline while an SRAM data access in MEM completes, using a small wait state machine.
- Sits beside the ID stage; receives destinations and enables from the ID/EX and EX/MEM registers.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/hazard_stall_unit_if.sv | 36 +++
 rtl/sram_wait_fsm.sv | 80 ++++++++
 rtl/hazard_stall_unit.sv | 48 ++++
 tb/tb_hazard_stall_unit.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall control slice.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W        = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
    localparam int unsigned SRAM_WAIT_DEFAULT = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } wait_state_e;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage control bundle: hazard sources in, stall/flush controls out.
interface hazard_stall_unit_if;
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  two_src;
    logic                  forward_en;
    logic [REG_ADDR_W-1:0] EXE_dest;
    logic                  EXE_WB_En;
    logic                  EXE_MEM_R_En;
    logic [REG_ADDR_W-1:0] MEM_dest;
    logic                  MEM_WB_En;
    logic                  mem_req;
    logic                  sram_ready;
    logic                  branch_taken;
    logic                  stall;
    logic                  superStall;
    logic                  flush;
    logic                  wait_busy;

    // Pipeline side.
    modport master (
        output src1, src2, two_src, forward_en, EXE_dest, EXE_WB_En, EXE_MEM_R_En,
        output MEM_dest, MEM_WB_En, mem_req, sram_ready, branch_taken,
        input  stall, superStall, flush, wait_busy
    );

    // Hazard/stall unit side.
    modport slave (
        input  src1, src2, two_src, forward_en, EXE_dest, EXE_WB_En, EXE_MEM_R_En,
        input  MEM_dest, MEM_WB_En, mem_req, sram_ready, branch_taken,
        output stall, superStall, flush, wait_busy
    );

endinterface

// File: rtl/sram_wait_fsm.sv
// Freezes the pipeline for each SRAM access in MEM. Define SRAM_READY_HS_EN to end
// the freeze on sram_ready instead of after SRAM_WAIT cycles.
module sram_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEFAULT,
    parameter int unsigned CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic sram_ready,
    output logic superStall,
    output logic wait_busy
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(SRAM_WAIT - 1);

    wait_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             freeze;

`ifndef SRAM_READY_HS_EN
    logic unused_sram_ready;
    assign unused_sram_ready = sram_ready;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        freeze  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_req) begin
                    freeze = 1'b1;
                    cnt_d  = CNT_W'(1);
`ifdef SRAM_READY_HS_EN
                    state_d = StWait;
`else
                    state_d = (SRAM_WAIT == 1) ? StDone : StWait;
`endif
                end
            end
            StWait: begin
                freeze = 1'b1;
`ifdef SRAM_READY_HS_EN
                // Counter is informational only here; hold it at all-ones.
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                if (sram_ready) state_d = StDone;
`else
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LastCnt) state_d = StDone;
`endif
            end
            StDone: begin
                // mem_req is not sampled here; the next access re-enters via idle.
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign superStall = freeze & ~rst;
    assign wait_busy  = (state_q == StWait) & ~rst;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection plus SRAM freeze control for the ID/EX register.
// Optional macro SRAM_READY_HS_EN selects handshake-terminated SRAM waits.
module hazard_stall_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEFAULT,
    parameter int unsigned CNT_W     = 4
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_unit_if.slave bus
);

    logic super_stall;
    logic wait_busy;
    logic match_e;
    logic match_m;
    logic hazard;

    sram_wait_fsm #(
        .SRAM_WAIT (SRAM_WAIT),
        .CNT_W     (CNT_W)
    ) u_sram_wait_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (bus.mem_req),
        .sram_ready (bus.sram_ready),
        .superStall (super_stall),
        .wait_busy  (wait_busy)
    );

    always_comb begin
        match_e = (bus.EXE_dest != ZERO_REG) &&
                  ((bus.EXE_dest == bus.src1) || (bus.two_src && (bus.EXE_dest == bus.src2)));
        match_m = (bus.MEM_dest != ZERO_REG) &&
                  ((bus.MEM_dest == bus.src1) || (bus.two_src && (bus.MEM_dest == bus.src2)));
        // With forwarding only a load result is too late to bypass.
        if (bus.forward_en) hazard = match_e && bus.EXE_MEM_R_En;
        else                hazard = (match_e && bus.EXE_WB_En) || (match_m && bus.MEM_WB_En);
    end

    // A freeze holds the branch in EXE; it flushes on the first advance cycle.
    assign bus.flush      = bus.branch_taken & ~super_stall & ~rst;
    assign bus.stall      = hazard & ~bus.branch_taken & ~super_stall & ~rst;
    assign bus.superStall = super_stall;
    assign bus.wait_busy  = wait_busy;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed cases then random traffic.
module tb_hazard_stall_unit;

    localparam int SramWait = 6;

    typedef struct {
        logic stall;
        logic super_stall;
        logic flush;
        logic wait_busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Reference model: cycles of freeze still owed after the current one.
    int   m_left = 0;
    bit   m_wait = 1'b0;
    bit   m_done = 1'b0;

    hazard_stall_unit_if bus ();

    hazard_stall_unit #(
        .SRAM_WAIT (SramWait),
        .CNT_W     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                         input logic ts, input logic fe, input logic [4:0] ed,
                         input logic ewb, input logic emr, input logic [4:0] md,
                         input logic mwb, input logic mr, input logic sr, input logic bt);
        exp_t e;
        bit   me, mm, haz, ss, wb;
        @(posedge clk);
        #1;
        rst = r;
        bus.src1 = s1;  bus.src2 = s2;  bus.two_src = ts;  bus.forward_en = fe;
        bus.EXE_dest = ed;  bus.EXE_WB_En = ewb;  bus.EXE_MEM_R_En = emr;
        bus.MEM_dest = md;  bus.MEM_WB_En = mwb;  bus.mem_req = mr;
        bus.sram_ready = sr;  bus.branch_taken = bt;

        me  = (ed != 0) && (ed == s1 || (ts && ed == s2));
        mm  = (md != 0) && (md == s1 || (ts && md == s2));
        haz = fe ? (me && emr) : ((me && ewb) || (mm && mwb));
        ss  = 1'b0;
        wb  = 1'b0;
        if (r) begin
            m_left = 0; m_wait = 1'b0; m_done = 1'b0;
        end else if (m_wait) begin
            ss = 1'b1;
            wb = 1'b1;
`ifdef SRAM_READY_HS_EN
            if (sr) begin m_wait = 1'b0; m_done = 1'b1; end
`else
            m_left--;
            if (m_left == 0) begin m_wait = 1'b0; m_done = 1'b1; end
`endif
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (mr) begin
            ss = 1'b1;
`ifdef SRAM_READY_HS_EN
            m_wait = 1'b1;
`else
            m_left = SramWait - 1;
            if (m_left == 0) m_done = 1'b1;
            else             m_wait = 1'b1;
`endif
        end
        e.super_stall = ss;
        e.wait_busy   = wb;
        e.flush       = !r && bt && !ss;
        e.stall       = !r && haz && !bt && !ss;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall", bus.stall, e.stall);
                chk("superStall", bus.superStall, e.super_stall);
                chk("flush", bus.flush, e.flush);
                chk("wait_busy", bus.wait_busy, e.wait_busy);
            end
        end
    end

    initial begin : stimulus
        bus.src1 = '0;  bus.src2 = '0;  bus.two_src = 1'b0;  bus.forward_en = 1'b0;
        bus.EXE_dest = '0;  bus.EXE_WB_En = 1'b0;  bus.EXE_MEM_R_En = 1'b0;
        bus.MEM_dest = '0;  bus.MEM_WB_En = 1'b0;  bus.mem_req = 1'b0;
        bus.sram_ready = 1'b0;  bus.branch_taken = 1'b0;

        // Reset with busy-looking inputs: all outputs must read 0.
        apply(1, 5, 0, 0, 1, 5, 1, 1, 0, 0, 1, 0, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use with forwarding, then same with EXE_dest = r0.
        apply(0, 5, 0, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0);
        apply(0, 5, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        // No forwarding, MEM match on src2 gated by two_src.
        apply(0, 1, 7, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        apply(0, 1, 7, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        // mem_req pulse with branch held and hazard present.
        apply(0, 5, 0, 0, 1, 5, 1, 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 8; i++) apply(0, 5, 0, 0, 1, 5, 1, 1, 0, 0, 0, i == 2, 1);
        apply(0, 5, 0, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0);
        // Reset in the middle of a wait, then idle.
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Back-to-back accesses: mem_req held through DONE.
        for (int i = 0; i < 16; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, i == 4, 0);

        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 99) == 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
